instruction_fetch: RTL and testbench

Fetch-side initiator for the byte-addressed, little-endian, combinational-read instruction memory. It owns the program counter and drives the memory read address. It registers each returned 32-bit word with its PC and presents it to decode over a valid/ready handshake. It also handles branch redirects, end-of-program halt and a misaligned-target fault.

---
 rtl/instruction_fetch.sv | 101 ++++++++++
 tb/tb_instruction_fetch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads a combinational instruction memory and hands
// registered {instruction, pc} pairs to decode over a valid/ready handshake.
module instruction_fetch #(
   parameter int ADDR_WIDTH  = 64,
   parameter int INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
   parameter int IMEM_BYTES  = 128
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic [ADDR_WIDTH-1:0]  read_address,
   input  logic [INSTR_WIDTH-1:0] instruction,
   input  logic                   branch_taken,
   input  logic [ADDR_WIDTH-1:0]  branch_target,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTR_WIDTH-1:0] out_instruction,
   output logic [ADDR_WIDTH-1:0]  out_pc,
   output logic                   halted,
   output logic                   fault,
   output logic [31:0]            fetch_count
);

   localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(IMEM_BYTES - 4);

   typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

   state_t                 state, state_next;
   logic [ADDR_WIDTH-1:0]  pc, pc_next;
   logic [ADDR_WIDTH-1:0]  pc_plus4;
   logic                   out_valid_next;
   logic [INSTR_WIDTH-1:0] out_instruction_next;
   logic [ADDR_WIDTH-1:0]  out_pc_next;
   logic                   fault_next;
   logic [31:0]            fetch_count_next;
   logic                   accept;
   logic                   load;

   assign read_address = pc;
   assign pc_plus4     = pc + ADDR_WIDTH'(4);
   assign accept       = out_valid & out_ready;
   assign load         = (state == RUN) & (!out_valid | out_ready) & !branch_taken;
   assign halted       = (state == HALT) & !out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= RUN;
         pc              <= RESET_PC;
         out_valid       <= 1'b0;
         out_instruction <= '0;
         out_pc          <= '0;
         fault           <= 1'b0;
         fetch_count     <= '0;
      end else begin
         state           <= state_next;
         pc              <= pc_next;
         out_valid       <= out_valid_next;
         out_instruction <= out_instruction_next;
         out_pc          <= out_pc_next;
         fault           <= fault_next;
         fetch_count     <= fetch_count_next;
      end
   end

   always_comb begin
      state_next           = state;
      pc_next              = pc;
      out_valid_next       = out_valid;
      out_instruction_next = out_instruction;
      out_pc_next          = out_pc;
      fault_next           = fault;
      fetch_count_next     = fetch_count;

      // A taken branch squashes the held word, so it never counts as a handshake.
      if (accept && !branch_taken)
         fetch_count_next = fetch_count + 32'd1;

      if (state == FAULT) begin
         out_valid_next = 1'b0;
      end else if (branch_taken) begin
         out_valid_next = 1'b0;
         if (branch_target[1:0] == 2'b00) begin
            pc_next    = branch_target;
            state_next = (branch_target > LAST_PC) ? HALT : RUN;
         end else begin
            state_next = FAULT;
            fault_next = 1'b1;
         end
      end else if (load) begin
         out_instruction_next = instruction;
         out_pc_next          = pc;
         out_valid_next       = 1'b1;
         pc_next              = pc_plus4;
         if (pc_plus4 > LAST_PC)
            state_next = HALT;
      end else if (accept) begin
         out_valid_next = 1'b0;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 16-byte little-endian program
// memory modelled combinationally in the bench.
module tb_instruction_fetch;

   localparam int AW = 64;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] read_address;
   logic [IW-1:0] instruction;
   logic          branch_taken;
   logic [AW-1:0] branch_target;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_instruction;
   logic [AW-1:0] out_pc;
   logic          halted;
   logic          fault;
   logic [31:0]   fetch_count;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mem [0:15];

   instruction_fetch #(
      .ADDR_WIDTH (AW),
      .INSTR_WIDTH(IW),
      .RESET_PC   ('0),
      .IMEM_BYTES (16)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .read_address   (read_address),
      .instruction    (instruction),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instruction(out_instruction),
      .out_pc         (out_pc),
      .halted         (halted),
      .fault          (fault),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   always_comb begin
      instruction = '0;
      if (read_address < 64'd16)
         instruction = {mem[{read_address[3:2], 2'd3}], mem[{read_address[3:2], 2'd2}],
                        mem[{read_address[3:2], 2'd1}], mem[{read_address[3:2], 2'd0}]};
   end

   task automatic tick();
      @(posedge clk);
      #1;
      $display("cycle t=%0t valid=%0b ready=%0b out_pc=%0d instr=%08h count=%0d halted=%0b fault=%0b",
               $time, out_valid, out_ready, out_pc, out_instruction, fetch_count, halted, fault);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; out_ready = 1'b1; branch_taken = 1'b0; branch_target = '0;
      #3;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      checks++; if (out_pc !== 64'd0) begin failures++; $display("FAIL reset_out_pc got=%0h exp=0", out_pc); end
      checks++; if (out_instruction !== 32'd0) begin failures++; $display("FAIL reset_instr got=%08h exp=0", out_instruction); end
      checks++; if (read_address !== 64'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", read_address); end
      checks++; if (halted !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", halted, fault); end
      checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_stream_and_halt();
      logic [IW-1:0] exp_instr [0:3];
      exp_instr[0] = 32'h8B1F03E5; exp_instr[1] = 32'hF84000A4;
      exp_instr[2] = 32'h8B040086; exp_instr[3] = 32'hF80010A6;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (out_valid !== 1'b1 || out_pc !== 64'(4*i)) begin failures++; $display("FAIL stream_pc%0d got=%0b/%0d exp=1/%0d", i, out_valid, out_pc, 4*i); end
         checks++; if (out_instruction !== exp_instr[i]) begin failures++; $display("FAIL stream_instr%0d got=%08h exp=%08h", i, out_instruction, exp_instr[i]); end
         checks++; if (fetch_count !== 32'(i)) begin failures++; $display("FAIL stream_count%0d got=%0d exp=%0d", i, fetch_count, i); end
      end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_pending got=%0b exp=0", halted); end
      tick();
      checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL stream_count_final got=%0d exp=4", fetch_count); end
      checks++; if (out_valid !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL halt_state got=%0b/%0b exp=0/1", out_valid, halted); end
      checks++; if (read_address !== 64'd16) begin failures++; $display("FAIL halt_addr got=%0d exp=16", read_address); end
      tick();
      checks++; if (out_valid !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL halt_hold got=%0b/%0b exp=0/1", out_valid, halted); end
      branch_taken = 1'b1; branch_target = 64'd0;
      tick();
      branch_taken = 1'b0;
      checks++; if (halted !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL halt_exit got=%0b/%0b exp=0/0", halted, out_valid); end
      tick();
      checks++; if (out_pc !== 64'd0 || out_instruction !== 32'h8B1F03E5) begin failures++; $display("FAIL halt_refetch got=%0d/%08h exp=0/8b1f03e5", out_pc, out_instruction); end
      checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL halt_refetch_count got=%0d exp=4", fetch_count); end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (out_valid !== 1'b1 || out_pc !== 64'd0 || out_instruction !== 32'h8B1F03E5) begin failures++; $display("FAIL stall_hold%0d got=%0b/%0d/%08h exp=1/0/8b1f03e5", i, out_valid, out_pc, out_instruction); end
         checks++; if (read_address !== 64'd4 || fetch_count !== 32'd4) begin failures++; $display("FAIL stall_addr%0d got=%0d/%0d exp=4/4", i, read_address, fetch_count); end
      end
      out_ready = 1'b1;
      tick();
      checks++; if (out_pc !== 64'd4 || out_instruction !== 32'hF84000A4) begin failures++; $display("FAIL stall_release got=%0d/%08h exp=4/f84000a4", out_pc, out_instruction); end
      checks++; if (fetch_count !== 32'd5) begin failures++; $display("FAIL stall_count got=%0d exp=5", fetch_count); end
   endtask

   task automatic test_branch_discard();
      branch_taken = 1'b1; branch_target = 64'd12;
      tick();
      branch_taken = 1'b0;
      checks++; if (out_valid !== 1'b0 || fetch_count !== 32'd5) begin failures++; $display("FAIL branch_squash got=%0b/%0d exp=0/5", out_valid, fetch_count); end
      checks++; if (read_address !== 64'd12) begin failures++; $display("FAIL branch_addr got=%0d exp=12", read_address); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 64'd12 || out_instruction !== 32'hF80010A6) begin failures++; $display("FAIL branch_target got=%0b/%0d/%08h exp=1/12/f80010a6", out_valid, out_pc, out_instruction); end
      tick();
      checks++; if (halted !== 1'b1 || fetch_count !== 32'd6) begin failures++; $display("FAIL branch_halt got=%0b/%0d exp=1/6", halted, fetch_count); end
   endtask

   task automatic test_branch_vs_load();
      branch_taken = 1'b1; branch_target = 64'd0;
      tick();
      checks++; if (out_valid !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL bvl_exit got=%0b/%0b exp=0/0", out_valid, halted); end
      branch_target = 64'd8;
      tick();
      branch_taken = 1'b0;
      checks++; if (out_valid !== 1'b0 || read_address !== 64'd8) begin failures++; $display("FAIL bvl_noload got=%0b/%0d exp=0/8", out_valid, read_address); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 64'd8 || out_instruction !== 32'h8B040086) begin failures++; $display("FAIL bvl_target got=%0b/%0d/%08h exp=1/8/8b040086", out_valid, out_pc, out_instruction); end
   endtask

   task automatic test_fault();
      branch_taken = 1'b1; branch_target = 64'd6;
      tick();
      checks++; if (fault !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL fault_set got=%0b/%0b exp=1/0", fault, out_valid); end
      checks++; if (read_address !== 64'd12 || fetch_count !== 32'd6) begin failures++; $display("FAIL fault_pc got=%0d/%0d exp=12/6", read_address, fetch_count); end
      branch_target = 64'd0;
      tick();
      branch_taken = 1'b0;
      checks++; if (fault !== 1'b1 || out_valid !== 1'b0 || read_address !== 64'd12) begin failures++; $display("FAIL fault_sticky got=%0b/%0b/%0d exp=1/0/12", fault, out_valid, read_address); end
      tick();
      checks++; if (fault !== 1'b1 || out_valid !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL fault_noload got=%0b/%0b/%0b exp=1/0/0", fault, out_valid, halted); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (fault !== 1'b0 || fetch_count !== 32'd0 || read_address !== 64'd0) begin failures++; $display("FAIL fault_async_clear got=%0b/%0d/%0d exp=0/0/0", fault, fetch_count, read_address); end
      rst_n = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 64'd0 || out_instruction !== 32'h8B1F03E5) begin failures++; $display("FAIL fault_refetch got=%0b/%0d/%08h exp=1/0/8b1f03e5", out_valid, out_pc, out_instruction); end
   endtask

   initial begin
      {mem[3], mem[2], mem[1], mem[0]}     = 32'h8B1F03E5;
      {mem[7], mem[6], mem[5], mem[4]}     = 32'hF84000A4;
      {mem[11], mem[10], mem[9], mem[8]}   = 32'h8B040086;
      {mem[15], mem[14], mem[13], mem[12]} = 32'hF80010A6;
      test_reset();
      test_stream_and_halt();
      test_stall();
      test_branch_discard();
      test_branch_vs_load();
      test_fault();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
